// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter with a per-register pending-write scoreboard.
// Optional feature: define RF_WB_RR_EN for round-robin arbitration (default is fixed priority).
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               rw_en,
    output logic [AW-1:0]      rw_addr,
    output logic [DW-1:0]      rw_data,
    input  logic               iss_en,
    input  logic [AW-1:0]      iss_addr,
    output logic               iss_ready,
    input  logic [AW-1:0]      q1_addr,
    input  logic [AW-1:0]      q2_addr,
    output logic               q1_busy,
    output logic               q2_busy,
    output logic               wb_err
);

    localparam int PW = $clog2(NREQ);
    localparam int NR = 1 << AW;

    logic [PW-1:0] gnt_idx;
    logic          gnt_any;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    int unsigned   idx;

`ifdef RF_WB_RR_EN
    logic [PW-1:0] rr_ptr;

    // Search starts at the pointer and wraps; first valid requester wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr) + k) % NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`else
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = k;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx[PW-1:0];
            end
        end
    end
`endif

    always_comb begin
        req_ready = '0;
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
        sel_addr = req_addr[gnt_idx*AW +: AW];
        sel_data = req_data[gnt_idx*DW +: DW];
    end

    // Address 0 is accepted but never written; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rw_en   <= 1'b0;
            rw_addr <= '0;
            rw_data <= '0;
        end else if (gnt_any) begin
            rw_en   <= (sel_addr != '0);
            rw_addr <= sel_addr;
            rw_data <= sel_data;
        end else begin
            rw_en   <= 1'b0;
        end
    end

    logic [1:0]    cnt [NR];
    logic [NR-1:0] inc_vec;
    logic [NR-1:0] dec_vec;
    logic          iss_fire;
    logic          dec_fire;

    assign iss_ready = (iss_addr == '0) || (cnt[iss_addr] != 2'd3);
    assign q1_busy   = (cnt[q1_addr] != 2'd0);
    assign q2_busy   = (cnt[q2_addr] != 2'd0);
    assign iss_fire  = iss_en && iss_ready && (iss_addr != '0);
    assign dec_fire  = rw_en && (rw_addr != '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned r = 1; r < NR; r++) begin
            inc_vec[r] = iss_fire && (iss_addr == AW'(r));
            dec_vec[r] = dec_fire && (rw_addr == AW'(r));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NR; r++) begin
                cnt[r] <= '0;
            end
            wb_err <= 1'b0;
        end else begin
            cnt[0] <= '0;
            for (int unsigned r = 1; r < NR; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + 2'd1;
                end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != 2'd0)) begin
                    cnt[r] <= cnt[r] - 2'd1;
                end
            end
            // Underflow on a write-back with no matching issue is sticky.
            if (dec_fire && (cnt[rw_addr] == 2'd0)) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and pending-write scoreboard for the integer register file. It shares the register file's single write port (`rw_en`/`rw_addr`/`rw_data`) among `NREQ` write-back requesters, such as the ALU pipe, the load unit and mul/div, through valid/ready handshakes. It also keeps a per-register pending-write count so decode can detect RAW/WAW hazards on its two read operands. It sits between the execute/memory write-back sources and the register file; the decode stage reads its busy outputs.

## Interface
Parameters:
- `NREQ`, default 3: number of write-back requesters (2..8).
- `AW`, default 5: register address width, equal to `REG_WIDTH`.
- `DW`, default 32: data width, equal to `DATA_WIDTH`.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NREQ  per-requester write request.
- `req_addr`  in  NREQ*AW  destination register per requester; requester i uses bits [i*AW +: AW].
- `req_data`  in  NREQ*DW  write data per requester.
- `req_ready`  out  NREQ  one-hot grant, combinational; at most one bit set.
- `rw_en`, `rw_addr`, `rw_data`  out  1/AW/DW  registered write port to the register file.
- `iss_en`  in  1  decode issues an instruction that will write `iss_addr`.
- `iss_addr`  in  AW  destination of the issued instruction.
- `iss_ready`  out  1  0 when `iss_addr`'s count is saturated; issue must stall.
- `q1_addr`, `q2_addr`  in  AW  operand query addresses.
- `q1_busy`, `q2_busy`  out  1  combinational: the queried register has a pending write.
- `wb_err`  out  1  sticky error flag.

## Operation
- Arbitration:
  - Each cycle the block grants exactly one valid requester, if any.
  - Handshake for requester i = `req_valid[i] && req_ready[i]`.
  - `req_ready[i]` depends only on `req_valid` and internal state, never on downstream backpressure; the write port never stalls.
- Write stage:
  - On a handshake, the next edge loads `rw_en=1` with `rw_addr`/`rw_data` taken from the winning requester.
  - With no handshake, `rw_en=0` and `rw_addr`/`rw_data` hold their previous values.
  - A handshake with address 0 is accepted but loads `rw_en=0`. Register 0 is never written.
- Scoreboard:
  - One 2-bit counter per register; register 0 is hard-wired to 0.
  - Increment when `iss_en && iss_ready && iss_addr!=0`.
  - Decrement when `rw_en && rw_addr!=0` (the registered stage). The count therefore drops in the same cycle the register file captures the data.
  - Increment and decrement on the same register in the same cycle: count unchanged.
  - `iss_ready = (count[iss_addr] != 3)`. Register 0 is always ready.
  - `qN_busy = (count[qN_addr] != 0)`.
- Error: `wb_err` is set, and held until reset, when a decrement targets a register whose count is 0. The counter stays at 0 in that case.

## Timing
- Reset values: `rw_en=0`, `rw_addr=0`, `rw_data=0`, `wb_err=0`, all counters 0, round-robin pointer 0.
- Handshake in cycle T: register file write-enable asserted in cycle T+1, data visible in the register file from T+2. In T+2, `busy` for that address falls if its count was 1.
- Issue in cycle T: `busy` reads 1 from T+1.
- Back-to-back grants are allowed every cycle.
- A requester that loses arbitration holds `req_valid`, `req_addr` and `req_data` stable until it is granted.
- `rst` asserted mid-operation: all state clears at that edge, and any in-flight write-back stage is dropped (`rw_en=0` in the next cycle).

## Configuration
- `RF_WB_RR_EN` defined:
  - Round-robin arbitration. The search starts at pointer p and wraps from NREQ-1 to 0.
  - After a grant to requester i, p becomes (i+1) mod NREQ. Without a grant, p is unchanged.
  - Starvation bound: NREQ-1 cycles.
- Not defined: fixed priority, lowest index wins, and the pointer logic is removed.

## Test plan
- Single write: r0 valid, addr 5, data 0xDEADBEEF in cycle T -> `req_ready=3'b001` in T; `rw_en=1`, `rw_addr=5`, `rw_data=0xDEADBEEF` in T+1; `rw_en=0` in T+2.
- Contention, RR build: all three requesters valid for 6 cycles -> grants 0,1,2,0,1,2. Non-RR build -> grant 0 in every cycle.
- Scoreboard: issue addr 7 three times -> `iss_ready=0` for addr 7. Then write back 7 once -> count 2, `iss_ready=1`. Then drain twice -> `q1_busy=0` the cycle after the second `rw_en`.
- Simultaneous events: issue addr 9 in the same cycle `rw_en` writes addr 9 with count 1 -> count stays 1, `busy` stays 1.
- Register 0 and error: handshake with addr 0 -> `rw_en` stays 0 and `wb_err` stays 0. Write-back to addr 3 with count 0 -> `wb_err=1` and sticky until `rst`.
- Mid-operation reset: handshake in T with `rst` high in T -> `rw_en=0` in T+1, all busy 0, `iss_ready=1`.
